id_ex_pipe: RTL

ID_EX_PIPE -- requirements
Module: id_ex_pipe

---
 rtl/id_ex_pipe_if.sv | 45 ++++
 rtl/id_ex_pipe.sv | 116 +++++++++++
 2 files changed

// File: rtl/id_ex_pipe_if.sv
// ID/EX stage bundle: upstream decode handshake and payload, downstream execute handshake
// and payload, pipeline control (flush/hold) and the bubble counter status.
interface id_ex_pipe_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RADDR_W = 5,
  parameter int unsigned CTRL_W  = 12,
  parameter int unsigned NOC_W   = 2,
  parameter int unsigned CNT_W   = 16
);
  logic               flush;
  logic               hold;
  logic               in_valid;
  logic               in_ready;
  logic [CTRL_W-1:0]  in_ctrl;
  logic [DATA_W-1:0]  in_rd1;
  logic [DATA_W-1:0]  in_rd2;
  logic [DATA_W-1:0]  in_imm;
  logic [DATA_W-1:0]  in_pc;
  logic [RADDR_W-1:0] in_radd;
  logic [NOC_W-1:0]   in_dest;
  logic               out_valid;
  logic               out_ready;
  logic [CTRL_W-1:0]  out_ctrl;
  logic [DATA_W-1:0]  out_rd1;
  logic [DATA_W-1:0]  out_rd2;
  logic [DATA_W-1:0]  out_imm;
  logic [DATA_W-1:0]  out_pc;
  logic [RADDR_W-1:0] out_radd;
  logic [NOC_W-1:0]   out_dest;
  logic [CNT_W-1:0]   bubble_cnt;

  modport master (
    output flush, hold, in_valid, in_ctrl, in_rd1, in_rd2, in_imm, in_pc, in_radd, in_dest,
    output out_ready,
    input  in_ready, out_valid, out_ctrl, out_rd1, out_rd2, out_imm, out_pc, out_radd,
    input  out_dest, bubble_cnt
  );

  modport slave (
    input  flush, hold, in_valid, in_ctrl, in_rd1, in_rd2, in_imm, in_pc, in_radd, in_dest,
    input  out_ready,
    output in_ready, out_valid, out_ctrl, out_rd1, out_rd2, out_imm, out_pc, out_radd,
    output out_dest, bubble_cnt
  );
endinterface

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with valid/ready handshake, flush, hold and a saturating bubble
// counter. Define ID_EX_SKID_EN to add a one-entry skid buffer with a registered in_ready.
module id_ex_pipe #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RADDR_W = 5,
  parameter int unsigned CTRL_W  = 12,
  parameter int unsigned NOC_W   = 2,
  parameter int unsigned CNT_W   = 16
) (
  input logic         clk,
  input logic         rst,
  id_ex_pipe_if.slave bus
);
  localparam int unsigned PAY_W = CTRL_W + 4 * DATA_W + RADDR_W + NOC_W;

  logic [PAY_W-1:0]  w_in_pay;
  logic [PAY_W-1:0]  r_pay, w_pay_d;
  logic              r_valid, w_valid_d;
  logic              w_in_ready, w_accept, w_xfer;
  logic [CNT_W-1:0]  r_bubble, w_bubble_d;
  logic [CTRL_W-1:0] w_ctrl;

  assign w_in_pay = {bus.in_ctrl, bus.in_rd1, bus.in_rd2, bus.in_imm, bus.in_pc, bus.in_radd,
                     bus.in_dest};
  assign w_accept = bus.in_valid && w_in_ready;
  assign w_xfer   = r_valid && bus.out_ready;

`ifdef ID_EX_SKID_EN
  logic [PAY_W-1:0] r_skid, w_skid_d;
  logic             r_skid_valid, w_skid_valid_d;
  logic             r_rdy;

  // r_rdy is registered, so in_ready never depends on out_ready in the same cycle
  assign w_in_ready = r_rdy && !bus.hold && !bus.flush && !rst;

  always_comb begin
    w_pay_d        = r_pay;
    w_valid_d      = r_valid;
    w_skid_d       = r_skid;
    w_skid_valid_d = r_skid_valid;
    if (bus.flush) begin
      w_valid_d      = 1'b0;
      w_skid_valid_d = 1'b0;
    end else if (w_xfer) begin
      if (r_skid_valid) begin
        w_pay_d        = r_skid;
        w_skid_valid_d = 1'b0;
      end else if (w_accept) begin
        w_pay_d = w_in_pay;
      end else begin
        w_valid_d = 1'b0;
      end
    end else if (w_accept) begin
      if (r_valid) begin
        w_skid_d       = w_in_pay;
        w_skid_valid_d = 1'b1;
      end else begin
        w_pay_d   = w_in_pay;
        w_valid_d = 1'b1;
      end
    end
  end
`else
  assign w_in_ready = !rst && !bus.flush && !bus.hold && (!r_valid || bus.out_ready);

  always_comb begin
    w_pay_d   = r_pay;
    w_valid_d = r_valid;
    if (bus.flush) begin
      w_valid_d = 1'b0;
    end else if (w_accept) begin
      w_pay_d   = w_in_pay;
      w_valid_d = 1'b1;
    end else if (w_xfer) begin
      w_valid_d = 1'b0;
    end
  end
`endif

  always_comb begin
    w_bubble_d = r_bubble;
    if (!r_valid && bus.out_ready && (r_bubble != {CNT_W{1'b1}})) begin
      w_bubble_d = r_bubble + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pay        <= '0;
      r_valid      <= 1'b0;
      r_bubble     <= '0;
`ifdef ID_EX_SKID_EN
      r_skid       <= '0;
      r_skid_valid <= 1'b0;
      r_rdy        <= 1'b1;
`endif
    end else begin
      r_pay        <= w_pay_d;
      r_valid      <= w_valid_d;
      r_bubble     <= w_bubble_d;
`ifdef ID_EX_SKID_EN
      r_skid       <= w_skid_d;
      r_skid_valid <= w_skid_valid_d;
      r_rdy        <= !w_skid_valid_d;
`endif
    end
  end

  assign {w_ctrl, bus.out_rd1, bus.out_rd2, bus.out_imm, bus.out_pc, bus.out_radd,
          bus.out_dest} = r_pay;
  // Bubbles carry no control so no register/memory side effects leak downstream
  assign bus.out_ctrl   = r_valid ? w_ctrl : '0;
  assign bus.out_valid  = r_valid;
  assign bus.in_ready   = w_in_ready;
  assign bus.bubble_cnt = r_bubble;
endmodule
